// File: rtl/pulse_stretch_pkg.sv
// Shared types and sizing helpers for the LED pulse stretcher and its tick
// generator.
package pulse_stretch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } state_e;

    // Prescaler width; at least one bit so a divide-by-one still elaborates.
    function automatic int unsigned ps_width(input int unsigned tick_div);
        return (tick_div <= 1) ? 1 : $clog2(tick_div);
    endfunction

    // Tick-count width sized for the longer of the ON and OFF phases.
    function automatic int unsigned tc_width(input int unsigned on_ticks,
                                             input int unsigned off_ticks);
        int unsigned m;
        m = (on_ticks > off_ticks) ? on_ticks : off_ticks;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/pulse_stretch_led_if.sv
// Event-in / LED-status-out bundle of the pulse stretcher.
// master: event source and status observer; slave: the stretcher itself.
interface pulse_stretch_led_if #(
    parameter int unsigned PEND_W = 4
) ();
    logic              pulse_in;
    logic              led_out;
    logic              busy;
    logic [PEND_W-1:0] pending;
    logic              overflow;

    modport master (
        output pulse_in,
        input  led_out,
        input  busy,
        input  pending,
        input  overflow
    );

    modport slave (
        input  pulse_in,
        output led_out,
        output busy,
        output pending,
        output overflow
    );
endinterface

// File: rtl/pulse_stretch_led_tick_gen.sv
// tick_gen: free-running prescaler that emits a one-cycle tick every TICK_DIV
// clocks. A synchronous clear restarts the period from zero.
module tick_gen
    import pulse_stretch_pkg::*;
#(
    parameter int unsigned TICK_DIV = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int unsigned PS_W = ps_width(TICK_DIV);

    logic [PS_W-1:0] cnt_q;
    logic [PS_W-1:0] cnt_d;

    // Tick on the last count of the period; wrap or clear otherwise.
    always_comb begin
        tick  = (cnt_q == PS_W'(TICK_DIV - 1));
        cnt_d = cnt_q + PS_W'(1);
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    // Prescaler register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/pulse_stretch_led.sv
// pulse_stretch_led: turns one-cycle event strobes into human-visible LED
// blinks of ON_TICKS lit / OFF_TICKS dark. Events arriving while busy are
// queued in a saturating pending counter; a dropped event sets sticky overflow.
// Optional macro RETRIGGER_EN: an event during ON restarts the ON period
// instead of queuing; events during OFF still queue.
module pulse_stretch_led
    import pulse_stretch_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 250000,
    parameter int unsigned ON_TICKS  = 40,
    parameter int unsigned OFF_TICKS = 40,
    parameter int unsigned PEND_W    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    pulse_stretch_led_if.slave   bus
);
    localparam int unsigned TC_W = tc_width(ON_TICKS, OFF_TICKS);

    state_e            state_q, state_d;
    logic [TC_W-1:0]   tcnt_q, tcnt_d;
    logic [PEND_W-1:0] pending_q, pending_d;
    logic              overflow_q, overflow_d;
    logic              led_q, led_d;
    logic              busy_q, busy_d;

    logic tick;
    logic restart;
    logic inc;
    logic dec;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (restart),
        .tick (tick)
    );

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            tcnt_q     <= '0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
            led_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tcnt_q     <= tcnt_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            led_q      <= led_d;
            busy_q     <= busy_d;
        end
    end

    // Next state, tick counting and pending-queue bookkeeping.
    always_comb begin
        state_d    = state_q;
        tcnt_d     = tick ? tcnt_q + TC_W'(1) : tcnt_q;
        pending_d  = pending_q;
        overflow_d = overflow_q;
        restart    = 1'b0;
        inc        = 1'b0;
        dec        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.pulse_in) begin
                    state_d = ON;
                    restart = 1'b1;
                end
            end
            ON: begin
`ifdef RETRIGGER_EN
                // A retrigger outranks the end of the ON period.
                if (bus.pulse_in) begin
                    restart = 1'b1;
                end else if (tick && tcnt_q == TC_W'(ON_TICKS - 1)) begin
                    state_d = OFF;
                    restart = 1'b1;
                end
`else
                inc = bus.pulse_in;
                if (tick && tcnt_q == TC_W'(ON_TICKS - 1)) begin
                    state_d = OFF;
                    restart = 1'b1;
                end
`endif
            end
            OFF: begin
                inc = bus.pulse_in;
                if (tick && tcnt_q == TC_W'(OFF_TICKS - 1)) begin
                    restart = 1'b1;
                    // A same-cycle event counts toward the next blink.
                    if (pending_q != '0 || bus.pulse_in) begin
                        state_d = ON;
                        dec     = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                restart = 1'b1;
            end
        endcase

        if (restart) begin
            tcnt_d = '0;
        end

        // Same-cycle increment and decrement cancel, even at saturation.
        if (inc && !dec) begin
            if (&pending_q) begin
                overflow_d = 1'b1;
            end else begin
                pending_d = pending_q + PEND_W'(1);
            end
        end else if (dec && !inc) begin
            pending_d = pending_q - PEND_W'(1);
        end
    end

    // Registered LED and busy follow the upcoming state.
    always_comb begin
        led_d  = (state_d == ON);
        busy_d = (state_d != IDLE);
    end

    assign bus.led_out  = led_q;
    assign bus.busy     = busy_q;
    assign bus.pending  = pending_q;
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_pulse_stretch_led.sv
// Directed bench for pulse_stretch_led with TICK_DIV=4, ON_TICKS=3,
// OFF_TICKS=2, PEND_W=2 (12-cycle ON, 8-cycle OFF).
module tb_pulse_stretch_led;
    localparam int unsigned TICK_DIV  = 4;
    localparam int unsigned ON_TICKS  = 3;
    localparam int unsigned OFF_TICKS = 2;
    localparam int unsigned PEND_W    = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int unsigned tests_run    = 0;
    int unsigned tests_failed = 0;

    pulse_stretch_led_if #(.PEND_W(PEND_W)) bus ();

    pulse_stretch_led #(
        .TICK_DIV  (TICK_DIV),
        .ON_TICKS  (ON_TICKS),
        .OFF_TICKS (OFF_TICKS),
        .PEND_W    (PEND_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive inputs for one cycle, then sample #1 after the edge.
    task automatic step(input logic p, input logic r);
        bus.pulse_in = p;
        rst          = r;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        step(1'b0, 1'b1);
    endtask

    task automatic check_all(input string name, input int c, input logic led,
                             input logic bsy, input int pend, input logic ovf);
        check_eq($sformatf("%s led c%0d", name, c), 32'(bus.led_out), 32'(led));
        check_eq($sformatf("%s busy c%0d", name, c), 32'(bus.busy), 32'(bsy));
        check_eq($sformatf("%s pend c%0d", name, c), 32'(bus.pending), 32'(pend));
        check_eq($sformatf("%s ovf c%0d", name, c), 32'(bus.overflow), 32'(ovf));
    endtask

    function automatic logic in_rng(input int c, input int lo, input int hi);
        return (c >= lo) && (c <= hi);
    endfunction

    initial begin
        bus.pulse_in = 1'b0;

        // Reset state
        apply_reset();
        check_all("reset", 0, 1'b0, 1'b0, 0, 1'b0);

        // Single event: lit 1..12, busy 1..20
        for (int c = 0; c <= 22; c++) begin
            check_all("single", c, in_rng(c, 1, 12), in_rng(c, 1, 20), 0, 1'b0);
            step(c == 0, 1'b0);
        end

`ifdef RETRIGGER_EN
        // Retrigger at 9 restarts ON: lit 1..21, OFF 22..29
        apply_reset();
        for (int c = 0; c <= 31; c++) begin
            check_all("retrig", c, in_rng(c, 1, 21), in_rng(c, 1, 29), 0, 1'b0);
            step(c == 0 || c == 9, 1'b0);
        end

        // Event during OFF still queues
        apply_reset();
        for (int c = 0; c <= 42; c++) begin
            check_all("offq", c, in_rng(c, 1, 12) || in_rng(c, 21, 32),
                      in_rng(c, 1, 40), in_rng(c, 16, 20) ? 1 : 0, 1'b0);
            step(c == 0 || c == 15, 1'b0);
        end
`else
        // Queued events: three blinks at 1, 21, 41
        apply_reset();
        for (int c = 0; c <= 62; c++) begin
            int pend;
            pend = (c < 6) ? 0 : (c < 8) ? 1 : (c < 21) ? 2 : (c < 41) ? 1 : 0;
            check_all("queue", c,
                      in_rng(c, 1, 12) || in_rng(c, 21, 32) || in_rng(c, 41, 52),
                      in_rng(c, 1, 60), pend, 1'b0);
            step(c == 0 || c == 5 || c == 7, 1'b0);
        end

        // Overflow: 4 pulses during ON saturate at 3, overflow sticks
        apply_reset();
        for (int c = 0; c <= 25; c++) begin
            int pend;
            pend = (c < 3) ? 0 : (c == 3) ? 1 : (c == 4) ? 2 : (c < 21) ? 3 : 2;
            check_all("ovf", c, in_rng(c, 1, 12) || in_rng(c, 21, 32),
                      c >= 1, pend, c >= 6);
            step(c == 0 || (c >= 2 && c <= 5), 1'b0);
        end
        apply_reset();
        check_all("ovf_clr", 0, 1'b0, 1'b0, 0, 1'b0);

        // Simultaneous increment and decrement on final OFF tick
        apply_reset();
        for (int c = 0; c <= 23; c++) begin
            check_all("simul", c, in_rng(c, 1, 12) || c >= 21, c >= 1,
                      (c >= 6) ? 1 : 0, 1'b0);
            step(c == 0 || c == 5 || c == 20, 1'b0);
        end

        // Reset mid-blink with overflow set, then a fresh full blink
        apply_reset();
        for (int c = 0; c <= 29; c++) begin
            if (c <= 6) begin
                check_all("rstmid", c, c >= 1, c >= 1,
                          (c < 3) ? 0 : (c == 3) ? 1 : (c == 4) ? 2 : 3, c == 6);
            end else begin
                check_all("rstmid", c, in_rng(c, 9, 20), in_rng(c, 9, 28), 0, 1'b0);
            end
            step(c == 0 || (c >= 2 && c <= 5) || c == 8, c == 6);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
